// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and slot/select mapping for the TDM demux.
package tdm_pkg;

    localparam int unsigned SLOTS     = 8;
    localparam int unsigned SLOT_BITS = 3;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [SLOT_BITS-1:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

    // Slot k maps to mux select {S1,S2,S3} = k, S1 being the MSB.
    function automatic slot_t slot_to_sel(input slot_t s);
        return s;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: clear, load-to-1 on sync, increment per accepted slot.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load1,
    input  logic                 inc,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 last_c
);

    // Increment wraps 7 -> 0 naturally at the end of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_BITS'(1);
        end else if (inc) begin
            slot <= slot + SLOT_BITS'(1);
        end
    end

    assign last_c = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_8.sv
// 8-channel TDM demultiplexer: locks on frame sync, collects slots into shadow
// registers and publishes a complete frame on q after the last slot.
module tdm_demux_8
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         din,
    input  logic                 valid,
    input  logic                 sync,
    output logic [SLOTS*W-1:0]   q,
    output logic                 frame_done,
    output logic [SLOT_BITS-1:0] slot,
    output logic                 locked,
    output logic                 sync_err
);

    state_e state;
    // Slot 7 goes straight from din into q, so only slots 0..6 need shadowing.
    logic [SLOTS-2:0][W-1:0] shadow;

    logic ctr_clear_c;
    logic ctr_load1_c;
    logic ctr_inc_c;
    logic last_c;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear_c),
        .load1  (ctr_load1_c),
        .inc    (ctr_inc_c),
        .slot   (slot),
        .last_c (last_c)
    );

    // Counter control mirrors the slot acceptance decisions of the FSM below.
    always_comb begin
        ctr_clear_c = 1'b0;
        ctr_load1_c = 1'b0;
        ctr_inc_c   = 1'b0;
        if (valid) begin
            case (state)
                HUNT: begin
                    ctr_load1_c = sync;
                end
                LOCKED: begin
                    if (sync) begin
                        ctr_load1_c = 1'b1;
                    end else if (slot == '0) begin
                        ctr_clear_c = 1'b1;
                    end else begin
                        ctr_inc_c = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            q          <= '0;
            shadow     <= '0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            shadow[0] <= din;
                            state     <= LOCKED;
                            locked    <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (sync) begin
                            // Early sync drops the partial frame and restarts at slot 0.
                            shadow[0] <= din;
                            if (slot != '0) begin
                                sync_err <= 1'b1;
                            end
                        end else if (slot == '0) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                            locked   <= 1'b0;
                        end else if (last_c) begin
                            q          <= {din, shadow};
                            frame_done <= 1'b1;
                        end else begin
                            shadow[slot_to_sel(slot)] <= din;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Scoreboard bench for tdm_demux_8: a frame-collecting reference model queues
// per-cycle expectations which an independent monitor compares after each edge.
module tb_tdm_demux_8;

    localparam int W = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     din = '0;
    logic             valid = 1'b0;
    logic             sync = 1'b0;
    logic [8*W-1:0]   q;
    logic             frame_done;
    logic [2:0]       slot;
    logic             locked;
    logic             sync_err;

    tdm_demux_8 #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .valid      (valid),
        .sync       (sync),
        .q          (q),
        .frame_done (frame_done),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           fd;
        logic           err;
        logic           lk;
        logic [2:0]     slot;
        logic [8*W-1:0] q;
    } exp_t;

    exp_t           exp_q[$];
    logic [W-1:0]   frame[$];
    bit             m_locked = 1'b0;
    logic [8*W-1:0] m_q = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of slot values since the last sync.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        valid = v;
        sync  = s;
        din   = d;
        e = '0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    frame.delete();
                    frame.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (s) begin
                if (frame.size() != 0) e.err = 1'b1;
                frame.delete();
                frame.push_back(d);
            end else if (frame.size() == 0) begin
                e.err = 1'b1;
                m_locked = 1'b0;
            end else begin
                frame.push_back(d);
                if (frame.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_q[k*W +: W] = frame[k];
                    e.fd = 1'b1;
                    frame.delete();
                end
            end
        end
        e.lk   = m_locked;
        e.slot = m_locked ? 3'(frame.size()) : 3'd0;
        e.q    = m_q;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        sync  = 1'b0;
        #1;
        check("rst_q", 64'(q), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_slot", 64'(slot), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_sync_err", 64'(sync_err), 64'd0);
        frame.delete();
        m_locked = 1'b0;
        m_q = '0;
        exp_q.push_back('0);
    endtask

    task automatic send_frame(input logic [8*W-1:0] data, input int gap_at, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) cycle(1'b0, 1'($urandom), W'($urandom));
            end
            cycle(1'b1, (k == 0), data[k*W +: W]);
        end
    endtask

    // Monitor: one queued expectation per clock edge once stimulus is running.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_done", 64'(frame_done), 64'(e.fd));
            check("sync_err", 64'(sync_err), 64'(e.err));
            check("locked", 64'(locked), 64'(e.lk));
            check("slot", 64'(slot), 64'(e.slot));
            check("q", 64'(q), 64'(e.q));
        end
    end

    initial begin
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, '0);

        // Basic frame: D1 and D8 set
        send_frame(8'b1000_0001, -1, 0);

        // Walk a one-hot channel across all eight slots
        for (int k = 0; k < 8; k++) send_frame(8'(1) << k, -1, 0);

        // Three idle cycles between slots 2 and 3
        send_frame(8'b1000_0001, 3, 3);

        // Early sync at slot 5, then a clean frame
        for (int k = 0; k < 5; k++) cycle(1'b1, (k == 0), W'($urandom));
        send_frame(8'h5A, -1, 0);
        send_frame(8'hE7, -1, 0);

        // Missing sync after a complete frame, then relock
        send_frame(8'hC3, -1, 0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0);
        send_frame(8'h3C, -1, 0);

        // Reset in the middle of a frame
        for (int k = 0; k < 4; k++) cycle(1'b1, (k == 0), W'($urandom));
        do_reset();
        repeat (10) cycle(1'b1, 1'b0, W'($urandom));
        send_frame(8'hA5, -1, 0);

        // Random traffic with occasional syncs and gaps
        repeat (400) cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), W'($urandom));
        for (int f = 0; f < 20; f++) send_frame(8'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 2)));

        repeat (3) cycle(1'b0, 1'b0, '0);
        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux_8.md
# tdm_demux_8

Time-division demultiplexer that recovers eight parallel channels from a serial slot stream produced by the 8:1 mux path. It locks to a frame-sync marker and steers each accepted slot into shadow register k, with k = 0..7 following the mux select order {S1,S2,S3} (S1 = MSB). On the last slot it publishes a registered 8-channel word. It is the receive-side counterpart of the mux and feeds downstream channel logic.

## Interface
- W, default 1: bits per slot (channel width).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  W  serial slot data.
- valid  input  1  din/sync qualifier; a slot is accepted only when valid = 1.
- sync  input  1  marks the current valid slot as slot 0 (channel D1); ignored when valid = 0.
- q  output  8*W  recovered frame; q[k*W +: W] = channel D(k+1).
- frame_done  output  1  one-cycle pulse: q has just been updated.
- slot  output  3  index of the next expected slot.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on an unexpected or missing sync.

## Operation
- States: HUNT and LOCKED. Reset enters HUNT.
- HUNT:
  - Valid slots without sync are discarded.
  - valid & sync stores din in shadow[0], sets slot = 1 and moves to LOCKED.
- LOCKED, valid slot with slot = k and no sync:
  - shadow[k] <= din, then slot increments.
  - When k = 7: q <= {din, shadow[6:0]}, frame_done pulses, slot wraps to 0.
- LOCKED, valid & sync with slot = 0: normal frame start; shadow[0] <= din, slot = 1. No error.
- LOCKED, valid & sync with slot ≠ 0 (early sync):
  - sync_err pulses and the partial frame is discarded.
  - The current din is taken as slot 0: shadow[0] <= din, slot = 1.
  - q is not updated.
- LOCKED, valid with slot = 0 and no sync (missing sync):
  - sync_err pulses.
  - The slot is discarded and the state returns to HUNT with slot = 0.
- valid = 0: no state change in either state. Gaps inside a frame are allowed.
- q holds its last published value until the next complete frame. Partial frames never reach q.

## Timing
- All outputs are registered.
- Reset values: q = 0, frame_done = 0, slot = 0, locked = 0, sync_err = 0, state = HUNT, shadow = 0.
- Reset is asynchronous. Asserting rst_n mid-frame clears everything immediately, and the next frame requires a fresh sync.
- Latency:
  - slot-7 din is sampled at edge N.
  - q and frame_done are valid after edge N (visible in cycle N+1).
  - frame_done lasts exactly one cycle.
- Minimum frame period is 8 consecutive valid cycles, which gives frame_done back-to-back every 8 cycles.
- sync_err is asserted in the cycle after the offending slot, for one cycle.
- locked rises the cycle after the first accepted sync and falls the cycle after a missing-sync error.

## Structure
- Package tdm_pkg holds:
  - SLOTS = 8 and SLOT_BITS = 3.
  - State enum {HUNT, LOCKED}.
  - Slot-to-select mapping (slot k ↔ {S1,S2,S3} = k).
- Sub-module tdm_slot_ctr: 3-bit slot counter with load-1 (sync), increment (valid) and clear, and a last-slot flag (slot = 7).
- Top level holds the FSM, the shadow registers, the q register and the pulse generation.

## Test plan
- Reset mid-frame:
  - Stimulus: lock, send 4 slots, pulse rst_n low.
  - Response: all outputs 0 at once; after release, slots without sync give locked = 0 and no frame_done.
- Basic frame, W = 1:
  - Stimulus: sync on slot 0, then data 1,0,0,0,0,0,0,1 for D1..D8.
  - Response: q = 8'b1000_0001 and frame_done high one cycle after slot 7.
- Mux walk-through:
  - Stimulus: eight frames, frame k one-hot on D(k+1) (k = 0..7).
  - Response: q = 8'h01, 02, 04, … 80 in sequence.
- valid gaps:
  - Stimulus: same frame with valid = 0 for 3 cycles between slots 2 and 3.
  - Response: identical q, and frame_done delayed by 3 cycles.
- Early sync:
  - Stimulus: sync at slot 5.
  - Response: sync_err pulse; q unchanged; the following 8 slots publish correctly with no further error.
- Missing sync:
  - Stimulus: after a complete frame, next valid slot with sync = 0.
  - Response: sync_err pulse; locked = 0; a subsequent sync relocks and the frame publishes.
